// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its write arbiter.
package regfile_mp_pkg;

  // Default datapath width and register address width.
  localparam int unsigned WORD              = 32;
  localparam int unsigned REG_ADDRESS_SPACE = 5;

  // Upper bounds on port counts supported by the read/write muxing.
  localparam int unsigned MAX_READ_PORTS  = 8;
  localparam int unsigned MAX_WRITE_PORTS = 4;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Per-address write select: for every register address, a one-hot vector
// naming the highest-index enabled write port that targets it, plus a hit flag.
module regfile_wr_arbiter
  import regfile_mp_pkg::*;
#(
  parameter int unsigned REG_AMOUNT = 32,
  parameter int unsigned ADDR_SPACE = REG_ADDRESS_SPACE,
  parameter int unsigned NUM_WRITE  = 2
) (
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_SPACE-1:0] wr_addr,
  output logic [REG_AMOUNT*NUM_WRITE-1:0] sel,
  output logic [REG_AMOUNT-1:0]           hit
);

  // Later (higher-index) ports overwrite the selection, so the top port wins.
  always_comb begin
    sel = '0;
    hit = '0;
    for (int unsigned a = 0; a < REG_AMOUNT; a++) begin
      for (int unsigned w = 0; w < NUM_WRITE; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_SPACE +: ADDR_SPACE] == ADDR_SPACE'(a))) begin
          sel[a*NUM_WRITE +: NUM_WRITE] = '0;
          sel[a*NUM_WRITE + w]          = 1'b1;
          hit[a]                        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardwired zero register, busy scoreboard and
// optional same-cycle write-to-read bypass.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned WIDTH         = WORD,
  parameter int unsigned REG_AMOUNT    = 32,
  parameter int unsigned ADDR_SPACE    = REG_ADDRESS_SPACE,
  parameter int unsigned ZERO_REGISTER = 0,
  parameter int unsigned NUM_READ      = 2,
  parameter int unsigned NUM_WRITE     = 2,
  parameter int unsigned BYPASS        = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_READ*ADDR_SPACE-1:0]  r_addr,
  output logic [NUM_READ*WIDTH-1:0]       r_data,
  output logic [NUM_READ-1:0]             r_busy,
  input  logic [NUM_WRITE-1:0]            wr_en,
  input  logic [NUM_WRITE*ADDR_SPACE-1:0] wr_addr,
  input  logic [NUM_WRITE*WIDTH-1:0]      wr_data,
  input  logic                            iss_en,
  input  logic [ADDR_SPACE-1:0]           iss_addr,
  output logic [REG_AMOUNT-1:0]           busy_vec
);

  logic [REG_AMOUNT*NUM_WRITE-1:0] sel;
  logic [REG_AMOUNT-1:0]           hit;
  logic [WIDTH-1:0]                wdata [REG_AMOUNT];
  logic [WIDTH-1:0]                regs_q [REG_AMOUNT];
  logic [REG_AMOUNT-1:0]           busy_q;
  logic [REG_AMOUNT-1:0]           busy_d;
  logic [REG_AMOUNT-1:0]           iss_dec;
  logic [ADDR_SPACE-1:0]           ra;

  regfile_wr_arbiter #(
    .REG_AMOUNT (REG_AMOUNT),
    .ADDR_SPACE (ADDR_SPACE),
    .NUM_WRITE  (NUM_WRITE)
  ) u_arb (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .sel     (sel),
    .hit     (hit)
  );

  // Winning write data per address; AND-OR mux since sel is one-hot.
  always_comb begin
    for (int unsigned a = 0; a < REG_AMOUNT; a++) begin
      wdata[a] = '0;
      for (int unsigned w = 0; w < NUM_WRITE; w++) begin
        if (sel[a*NUM_WRITE + w]) begin
          wdata[a] = wdata[a] | wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Register storage; the zero register is never written and stays 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < REG_AMOUNT; a++) begin
        regs_q[a] <= '0;
      end
    end else begin
      for (int unsigned a = 0; a < REG_AMOUNT; a++) begin
        if (hit[a] && (a != ZERO_REGISTER)) begin
          regs_q[a] <= wdata[a];
        end
      end
    end
  end

  // Scoreboard next state: writeback clears, issue sets, and issue wins a tie
  // because the new producer supersedes the one writing back.
  always_comb begin
    iss_dec = '0;
    if (iss_en) begin
      iss_dec[iss_addr] = 1'b1;
    end
    iss_dec[ZERO_REGISTER] = 1'b0;
    busy_d = (busy_q & ~hit) | iss_dec;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // Read ports; outputs are forced to 0 while reset is asserted so that a
  // bypassed write cannot leak through during reset.
  always_comb begin
    r_data = '0;
    r_busy = '0;
    ra     = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      ra = r_addr[i*ADDR_SPACE +: ADDR_SPACE];
      if (rst_n && (ra != ADDR_SPACE'(ZERO_REGISTER))) begin
        if ((BYPASS != 0) && hit[ra]) begin
          r_data[i*WIDTH +: WIDTH] = wdata[ra];
          r_busy[i]                = busy_q[ra] & iss_dec[ra];
        end else begin
          r_data[i*WIDTH +: WIDTH] = regs_q[ra];
          r_busy[i]                = busy_q[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench: a 4R3W bypassing instance and a 2R2W
// non-bypassing instance driven side by side.
module tb_regfile_mp;

  logic clk;
  logic rst_n;

  // Instance A: 4 read, 3 write, bypass on.
  logic [19:0]  ra_addr;
  logic [127:0] ra_data;
  logic [3:0]   ra_busy;
  logic [2:0]   wa_en;
  logic [14:0]  wa_addr;
  logic [95:0]  wa_data;
  logic         ia_en;
  logic [4:0]   ia_addr;
  logic [31:0]  busy_a;

  // Instance B: 2 read, 2 write, bypass off.
  logic [9:0]   rb_addr;
  logic [63:0]  rb_data;
  logic [1:0]   rb_busy;
  logic [1:0]   wb_en;
  logic [9:0]   wb_addr;
  logic [63:0]  wb_data;
  logic         ib_en;
  logic [4:0]   ib_addr;
  logic [31:0]  busy_b;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_mp #(
    .WIDTH (32), .REG_AMOUNT (32), .ADDR_SPACE (5), .ZERO_REGISTER (0),
    .NUM_READ (4), .NUM_WRITE (3), .BYPASS (1)
  ) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_addr   (ra_addr),
    .r_data   (ra_data),
    .r_busy   (ra_busy),
    .wr_en    (wa_en),
    .wr_addr  (wa_addr),
    .wr_data  (wa_data),
    .iss_en   (ia_en),
    .iss_addr (ia_addr),
    .busy_vec (busy_a)
  );

  regfile_mp #(
    .WIDTH (32), .REG_AMOUNT (32), .ADDR_SPACE (5), .ZERO_REGISTER (0),
    .NUM_READ (2), .NUM_WRITE (2), .BYPASS (0)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .r_addr   (rb_addr),
    .r_data   (rb_data),
    .r_busy   (rb_busy),
    .wr_en    (wb_en),
    .wr_addr  (wb_addr),
    .wr_data  (wb_data),
    .iss_en   (ib_en),
    .iss_addr (ib_addr),
    .busy_vec (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = '0;
    wb_en = '0;
    ia_en = 1'b0;
    ib_en = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    idle();
    wa_addr = '0; wa_data = '0; ia_addr = '0;
    wb_addr = '0; wb_data = '0; ib_addr = '0;
    ra_addr = {5'd9, 5'd7, 5'd3, 5'd5};
    rb_addr = {5'd7, 5'd3};

    // Reset held, before any clock edge.
    #2;
    chk("reset_ra_data", ra_data, 128'h0);
    chk("reset_ra_busy", ra_busy, 4'h0);
    chk("reset_busy_a", busy_a, 32'h0);
    chk("reset_rb_data", rb_data, 64'h0);
    chk("reset_busy_b", busy_b, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Write 0xDEAD to reg 5, then pulse reset asynchronously.
    wa_en = 3'b001; wa_addr[4:0] = 5'd5; wa_data[31:0] = 32'hDEAD;
    #1 chk("bypass_reg5", ra_data[31:0], 32'hDEAD);
    tick();
    idle();
    #1 chk("stored_reg5", ra_data[31:0], 32'hDEAD);
    #1 rst_n = 1'b0;
    #1 chk("async_rst_reg5", ra_data[31:0], 32'h0);
    chk("async_rst_busy", busy_a, 32'h0);
    #1 rst_n = 1'b1;
    #1 chk("post_rst_reg5", ra_data[31:0], 32'h0);
    tick();

    // Zero register: write and issue are both ignored.
    wa_en = 3'b001; wa_addr[4:0] = 5'd0; wa_data[31:0] = 32'hFFFF_FFFF;
    ia_en = 1'b1; ia_addr = 5'd0;
    ra_addr[4:0] = 5'd0;
    #1 chk("zero_same_cycle", ra_data[31:0], 32'h0);
    chk("zero_rbusy", ra_busy[0], 1'b0);
    tick();
    idle();
    #1 chk("zero_busy_1", busy_a, 32'h0);
    chk("zero_read_1", ra_data[31:0], 32'h0);
    tick();
    chk("zero_busy_2", busy_a, 32'h0);

    // Two-port collision on reg 3: port 1 wins.
    wa_en = 3'b011; wa_addr[9:0] = {5'd3, 5'd3}; wa_data[63:0] = {32'h22, 32'h11};
    wb_en = 2'b11;  wb_addr = {5'd3, 5'd3};      wb_data = {32'h22, 32'h11};
    #1 chk("coll_a_same", ra_data[63:32], 32'h22);
    chk("coll_b_same_old", rb_data[31:0], 32'h0);
    tick();
    idle();
    #1 chk("coll_a_next", ra_data[63:32], 32'h22);
    chk("coll_b_next", rb_data[31:0], 32'h22);

    // Three-way collision on reg 4: port 2 wins.
    wa_en = 3'b111; wa_addr = {5'd4, 5'd4, 5'd4}; wa_data = {32'hC, 32'hB, 32'hA};
    ra_addr[4:0] = 5'd4;
    #1 chk("coll3_same", ra_data[31:0], 32'hC);
    tick();
    // Distinct addresses on two ports both land.
    wa_en = 3'b011; wa_addr[9:0] = {5'd8, 5'd6}; wa_data[63:0] = {32'h88, 32'h66};
    ra_addr = {5'd9, 5'd4, 5'd8, 5'd6};
    #1 chk("dist_byp_p0", ra_data[31:0], 32'h66);
    chk("dist_byp_p1", ra_data[63:32], 32'h88);
    tick();
    idle();
    #1 chk("dist_reg6", ra_data[31:0], 32'h66);
    chk("dist_reg8", ra_data[63:32], 32'h88);
    chk("coll3_reg4", ra_data[95:64], 32'hC);
    ra_addr = {5'd9, 5'd7, 5'd3, 5'd5};

    // Scoreboard lifecycle on reg 7.
    ia_en = 1'b1; ia_addr = 5'd7;
    ib_en = 1'b1; ib_addr = 5'd7;
    tick();
    idle();
    tick(); tick(); tick();
    chk("sb_busy_a", busy_a, 32'h0000_0080);
    chk("sb_rbusy_a", ra_busy[2], 1'b1);
    chk("sb_busy_b", busy_b, 32'h0000_0080);
    chk("sb_rbusy_b", rb_busy[1], 1'b1);
    wa_en = 3'b010; wa_addr[9:5] = 5'd7; wa_data[63:32] = 32'h42;
    wb_en = 2'b10;  wb_addr[9:5] = 5'd7; wb_data[63:32] = 32'h42;
    #1 chk("wb_rbusy_a_byp", ra_busy[2], 1'b0);
    chk("wb_rdata_a_byp", ra_data[95:64], 32'h42);
    chk("wb_busy_a_held", busy_a, 32'h0000_0080);
    chk("wb_rbusy_b_nobyp", rb_busy[1], 1'b1);
    chk("wb_rdata_b_old", rb_data[63:32], 32'h0);
    tick();
    idle();
    #1 chk("wb_busy_a_clr", busy_a, 32'h0);
    chk("wb_rbusy_a_clr", ra_busy[2], 1'b0);
    chk("wb_reg7_a", ra_data[95:64], 32'h42);
    chk("wb_busy_b_clr", busy_b, 32'h0);
    chk("wb_reg7_b", rb_data[63:32], 32'h42);

    // Set/clear race on reg 9: issue wins.
    ia_en = 1'b1; ia_addr = 5'd9;
    tick();
    idle();
    #1 chk("race_busy_pre", busy_a, 32'h0000_0200);
    chk("race_rbusy_pre", ra_busy[3], 1'b1);
    wa_en = 3'b001; wa_addr[4:0] = 5'd9; wa_data[31:0] = 32'h5;
    ia_en = 1'b1; ia_addr = 5'd9;
    #1 chk("race_rbusy_same", ra_busy[3], 1'b1);
    chk("race_rdata_same", ra_data[127:96], 32'h5);
    tick();
    idle();
    #1 chk("race_busy_post", busy_a, 32'h0000_0200);
    chk("race_reg9", ra_data[127:96], 32'h5);
    chk("race_rbusy_post", ra_busy[3], 1'b1);
    wa_en = 3'b001; wa_addr[4:0] = 5'd9; wa_data[31:0] = 32'h6;
    tick();
    idle();
    #1 chk("race_clear", busy_a, 32'h0);

    // Reset mid-operation: pending write and scoreboard both dropped.
    ia_en = 1'b1; ia_addr = 5'd12;
    tick();
    idle();
    #1 chk("mid_busy_pre", busy_a, 32'h0000_1000);
    wa_en = 3'b001; wa_addr[4:0] = 5'd5; wa_data[31:0] = 32'h77;
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_busy", busy_a, 32'h0);
    chk("mid_rst_rdata", ra_data, 128'h0);
    chk("mid_rst_rbusy", ra_busy, 4'h0);
    @(posedge clk);
    #1 idle();
    rst_n = 1'b1;
    tick();
    chk("mid_lost_reg5", ra_data[31:0], 32'h0);
    chk("mid_cleared_reg9", ra_data[127:96], 32'h0);
    chk("mid_cleared_reg7", ra_data[95:64], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
